sdram_client_arbiter: RTL and testbench

- Parametrised N-client arbiter that multiplexes byte-wide toggle-handshake memory clients onto one toggle-handshake SDRAM controller port.
- Successor to the fixed two-port wiring, where the DMA engine and MMC64 RAM each own a dedicated controller port. Any number of clients can now share one port.
- Adds round-robin or fixed-priority arbitration, optional ack synchronisation for a controller running in another clock domain, and per-transaction grant reporting.
- Sits between system-clock clients (dma_engine, mmc64, future units) and the SDRAM controller.

---
 rtl/sdram_client_arbiter_pkg.sv | 22 ++
 rtl/toggle_sync.sv | 31 +++
 rtl/sdram_client_arbiter.sv | 117 +++++++++++
 tb/tb_sdram_client_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_client_arbiter_pkg.sv
// Shared definitions for the SDRAM client arbiter: arbitration modes,
// FSM state encoding and a width helper for client indices.
package sdram_client_arbiter_pkg;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Flop chain bringing a toggle signal from another clock domain into clk.
// STAGES = 0 passes the signal straight through.
module toggle_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] chain;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain <= '0;
        end else begin
          chain[0] <= d;
          for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
      end

      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sdram_client_arbiter.sv
// N-client toggle-handshake arbiter sharing one SDRAM controller port,
// with round-robin or fixed-priority selection and optional ack synchronisation.
module sdram_client_arbiter
  import sdram_client_arbiter_pkg::*;
#(
  parameter int unsigned CLIENTS     = 4,
  parameter int unsigned A_BITS      = 24,
  parameter int unsigned D_BITS      = 8,
  parameter int unsigned PRIO_MODE   = PRIO_RR,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned GW         = clog2_min1(CLIENTS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CLIENTS-1:0]        client_req,
  output logic [CLIENTS-1:0]        client_ack,
  input  logic [CLIENTS-1:0]        client_we,
  input  logic [CLIENTS*A_BITS-1:0] client_a,
  input  logic [CLIENTS*D_BITS-1:0] client_d,
  output logic [CLIENTS*D_BITS-1:0] client_q,
  output logic                      ram_req,
  input  logic                      ram_ack,
  output logic                      ram_we,
  output logic [A_BITS-1:0]         ram_a,
  output logic [D_BITS-1:0]         ram_d,
  input  logic [D_BITS-1:0]         ram_q,
  output logic                      busy,
  output logic [GW-1:0]             grant_id
);

  arb_state_t         state_q, state_d;
  logic [CLIENTS-1:0] pending;
  logic [GW-1:0]      ptr_q, winner, ptr_next;
  logic               ack_s, done, do_grant, do_finish;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ram_ack),
    .q       (ack_s)
  );

  assign pending = client_req ^ client_ack;
  assign done    = (ack_s == ram_req);

  // First pending index scanning upward from start, wrapping at CLIENTS.
  function automatic logic [GW-1:0] pick(input logic [CLIENTS-1:0] pend,
                                         input logic [GW-1:0] start);
    logic [GW-1:0] sel;
    logic          found;
    int unsigned   idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < CLIENTS; k++) begin
      idx = (32'(start) + k) % CLIENTS;
      if (!found && pend[GW'(idx)]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign winner   = pick(pending, (PRIO_MODE == PRIO_FIXED) ? '0 : ptr_q);
  assign ptr_next = (32'(winner) == CLIENTS - 1) ? '0 : winner + GW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      IDLE: if (|pending) begin
        do_grant = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (done) begin
        do_finish = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      client_ack <= '0;
      client_q   <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_a      <= '0;
      ram_d      <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      ptr_q      <= '0;
    end else begin
      if (do_grant) begin
        ram_we   <= client_we[winner];
        ram_a    <= client_a[winner*A_BITS +: A_BITS];
        ram_d    <= client_d[winner*D_BITS +: D_BITS];
        grant_id <= winner;
        busy     <= 1'b1;
        ram_req  <= ~ram_req;
        if (PRIO_MODE == PRIO_RR) ptr_q <= ptr_next;
      end
      if (do_finish) begin
        if (!ram_we) client_q[grant_id*D_BITS +: D_BITS] <= ram_q;
        client_ack[grant_id] <= ~client_ack[grant_id];
        busy                 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench: slot 0 is round-robin with a 2-stage ack sync,
// slot 1 is fixed priority in the same clock domain.
module tb_sdram_client_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]    c_req [2];
  logic [N-1:0]    c_ack [2];
  logic [N-1:0]    c_we  [2];
  logic [N*AW-1:0] c_a   [2];
  logic [N*DW-1:0] c_d   [2];
  logic [N*DW-1:0] c_q   [2];
  logic            r_req [2];
  logic            r_ack [2];
  logic            r_we  [2];
  logic [AW-1:0]   r_a   [2];
  logic [DW-1:0]   r_d   [2];
  logic [DW-1:0]   r_q   [2];
  logic            busy  [2];
  logic [1:0]      gid   [2];

  logic [N-1:0]    exp_ack  [2];
  logic [N*DW-1:0] exp_q    [2];
  logic            exp_rreq [2];

  int checks = 0;
  int errors = 0;

  sdram_client_arbiter #(.CLIENTS(N), .A_BITS(AW), .D_BITS(DW), .PRIO_MODE(0), .SYNC_STAGES(2)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .client_req(c_req[0]), .client_ack(c_ack[0]), .client_we(c_we[0]),
    .client_a(c_a[0]), .client_d(c_d[0]), .client_q(c_q[0]),
    .ram_req(r_req[0]), .ram_ack(r_ack[0]), .ram_we(r_we[0]),
    .ram_a(r_a[0]), .ram_d(r_d[0]), .ram_q(r_q[0]),
    .busy(busy[0]), .grant_id(gid[0])
  );

  sdram_client_arbiter #(.CLIENTS(N), .A_BITS(AW), .D_BITS(DW), .PRIO_MODE(1), .SYNC_STAGES(0)) u_fx (
    .clk(clk), .reset_n(reset_n),
    .client_req(c_req[1]), .client_ack(c_ack[1]), .client_we(c_we[1]),
    .client_a(c_a[1]), .client_d(c_d[1]), .client_q(c_q[1]),
    .ram_req(r_req[1]), .ram_ack(r_ack[1]), .ram_we(r_we[1]),
    .ram_a(r_a[1]), .ram_d(r_d[1]), .ram_q(r_q[1]),
    .busy(busy[1]), .grant_id(gid[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int s, input int g, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_we[s][g]          = we;
    c_a[s][g*AW +: AW]  = a;
    c_d[s][g*DW +: DW]  = d;
    c_req[s][g]         = ~c_req[s][g];
  endtask

  // Grant on the next edge, controller answers after `delay` cycles,
  // client ack expected SYNC_STAGES+1 edges after the ram_ack toggle.
  task automatic txn(input int s, input int g, input logic [AW-1:0] a, input logic we,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int delay);
    int lat;
    lat = (s == 0) ? 3 : 1;
    tick();
    exp_rreq[s] = ~exp_rreq[s];
    check("grant_id", gid[s], g);
    check("ram_req", r_req[s], exp_rreq[s]);
    check("busy_grant", busy[s], 1);
    check("ram_a", r_a[s], a);
    check("ram_we", r_we[s], we);
    if (we) check("ram_d", r_d[s], wd);
    repeat (delay) tick();
    r_q[s]   = rd;
    r_ack[s] = ~r_ack[s];
    repeat (lat - 1) begin
      tick();
      check("busy_wait", busy[s], 1);
      check("ack_early", c_ack[s], exp_ack[s]);
    end
    tick();
    exp_ack[s][g] = ~exp_ack[s][g];
    if (!we) exp_q[s][g*DW +: DW] = rd;
    check("client_ack", c_ack[s], exp_ack[s]);
    check("client_q", c_q[s], exp_q[s]);
    check("busy_done", busy[s], 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      c_req[s] = '0; c_we[s] = '0; c_a[s] = '0; c_d[s] = '0;
      r_ack[s] = 1'b0; r_q[s] = '0;
      exp_ack[s] = '0; exp_q[s] = '0; exp_rreq[s] = 1'b0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_client_ack", c_ack[s], 0);
      check("rst_client_q", c_q[s], 0);
      check("rst_ram_req", r_req[s], 0);
      check("rst_ram_we", r_we[s], 0);
      check("rst_ram_a", r_a[s], 0);
      check("rst_ram_d", r_d[s], 0);
      check("rst_busy", busy[s], 0);
      check("rst_grant_id", gid[s], 0);
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Round-robin: 0,1,3 together from reset, then 0,1, then 3 before 0 (ptr at 2)
    post(0, 0, 0, 24'h000100, 8'h00);
    post(0, 1, 0, 24'h000101, 8'h00);
    post(0, 3, 0, 24'h000103, 8'h00);
    txn(0, 0, 24'h000100, 0, 8'h00, 8'h10, 2);
    txn(0, 1, 24'h000101, 0, 8'h00, 8'h11, 2);
    txn(0, 3, 24'h000103, 0, 8'h00, 8'h13, 2);
    post(0, 0, 0, 24'h000200, 8'h00);
    post(0, 1, 0, 24'h000201, 8'h00);
    txn(0, 0, 24'h000200, 0, 8'h00, 8'h20, 1);
    txn(0, 1, 24'h000201, 0, 8'h00, 8'h21, 1);
    post(0, 0, 0, 24'h000300, 8'h00);
    post(0, 3, 0, 24'h000303, 8'h00);
    txn(0, 3, 24'h000303, 0, 8'h00, 8'h33, 1);
    txn(0, 0, 24'h000300, 0, 8'h00, 8'h30, 1);
    repeat (4) tick();
    check("no_extra_ack", c_ack[0], exp_ack[0]);
    check("idle_busy", busy[0], 0);
    check("idle_ram_req", r_req[0], exp_rreq[0]);
    check("ram_a_hold_rr", r_a[0], 24'h000300);

    // Single read and write from a fresh reset
    do_reset();
    post(0, 2, 0, 24'h123456, 8'h00);
    txn(0, 2, 24'h123456, 0, 8'h00, 8'h5A, 5);
    post(0, 1, 1, 24'h000010, 8'hA5);
    txn(0, 1, 24'h000010, 1, 8'hA5, 8'hEE, 3);
    repeat (3) tick();
    check("ram_a_hold", r_a[0], 24'h000010);
    check("ram_d_hold", r_d[0], 8'hA5);
    check("ram_we_hold", r_we[0], 1);

    // Fixed priority: client 3 starves while client 0 keeps re-requesting
    for (int k = 0; k < 5; k++) begin
      post(1, 0, 0, 24'h000A00 + k, 8'h00);
      if (k == 0) post(1, 3, 0, 24'h000333, 8'h00);
      txn(1, 0, 24'h000A00 + k, 0, 8'h00, 8'h40 + k, 2);
    end
    txn(1, 3, 24'h000333, 0, 8'h00, 8'hC3, 2);

    // Reset while waiting on the controller, then a normal transaction
    post(0, 0, 0, 24'h0000AA, 8'h00);
    tick();
    check("busy_before_rst", busy[0], 1);
    #3;
    do_reset();
    post(0, 0, 0, 24'h000777, 8'h00);
    txn(0, 0, 24'h000777, 0, 8'h00, 8'h3C, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
